sysbus_arbiter: RTL and testbench
=================================

// Module: sysbus_arbiter
// PURPOSE
//  Shares the single Sysbus master port between two requesters: m0 = instruction fetch, m1 = data side.
//  Grants one whole transaction at a time: request, write beats, then read-response beats.
//  Arbitrates round-robin, steers response beats back to the owner, and enforces one outstanding transaction.
//  Sits between the core's fetch/data units and the top-level Sysbus.
// PARAMETERS
//  WRITE_BEATS  8   64-bit data beats following a write request (64-byte line)
//  TAG_W        13  request/response tag width, Sysbus layout {rw, kind[3:0], id[7:0]}
// PORTS
//  clk          in   1      Sysbus clock; all state changes on posedge
//  reset        in   1      synchronous, active-high
//  mN_reqcyc    in   1      requester N (N=0,1) request valid; held with req/reqtag until mN_reqack
//  mN_req       in   64     requester N address (first beat), then write data beats
//  mN_reqtag    in   TAG_W  requester N tag; bit TAG_W-1: 1=READ, 0=WRITE
//  mN_reqack    out  1      beat accepted by the bus, for requester N
//  mN_respcyc   out  1      response beat valid, to requester N
//  mN_resp      out  64     response data (bus_resp broadcast to both requesters)
//  mN_resptag   out  TAG_W  response tag (broadcast)
//  mN_respack   in   1      requester N accepts the response beat
//  bus_reqcyc   out  1      to Sysbus reqcyc
//  bus_req      out  64     to Sysbus req
//  bus_reqtag   out  TAG_W  to Sysbus reqtag
//  bus_reqack   in   1      from Sysbus reqack
//  bus_respcyc  in   1      from Sysbus respcyc
//  bus_resp     in   64     from Sysbus resp
//  bus_resptag  in   TAG_W  from Sysbus resptag
//  bus_respack  out  1      to Sysbus respack
//  unexp_resp   out  1      one-cycle pulse: response beat arrived with no read outstanding
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=1 (m0 wins the first tie), beat_cnt=0.
//   All outputs 0 while reset is high and in the cycle after. Reset mid-transaction abandons it silently.
//  FSM states: IDLE, ISSUE, WDATA, WAIT, RESP.
//  IDLE
//   Samples mN_reqcyc. One requester -> grant it. Both -> grant the one != last_grant.
//   Latches grant, req and reqtag -> ISSUE. bus_reqcyc rises 1 cycle after mN_reqcyc is first seen.
//  ISSUE
//   Drives bus_reqcyc=1 with the latched req/reqtag. Holds until bus_reqack.
//   mN_reqack = bus_reqack & grant==N (combinational); the other requester never sees ack.
//   On ack: WRITE -> WDATA with beat_cnt=0; READ -> WAIT.
//  WDATA
//   Passes through bus_reqcyc=mG_reqcyc and bus_req=mG_req; mG_reqack=bus_reqack.
//   beat_cnt++ on each acked beat. Ack of beat WRITE_BEATS-1 -> IDLE, last_grant<=grant.
//   Writes get no response.
//  WAIT
//   bus_reqcyc=0. First bus_respcyc -> RESP. That beat is forwarded in the same cycle.
//  WAIT/RESP response forwarding (combinational)
//   mG_respcyc=bus_respcyc; bus_respack=mG_respack; the other mN_respcyc=0.
//  RESP
//   A cycle with bus_respcyc=0 ends the burst -> IDLE, last_grant<=grant.
//   A new request may be granted in that same IDLE cycle's successor.
//  bus_respcyc in IDLE/ISSUE/WDATA
//   bus_respack=1 (beat dropped), unexp_resp=1 for that cycle, no mN_respcyc.
//  Ungranted requester's mN_reqcyc is ignored; it must hold request and tag stable.
//   No starvation: a waiting requester is granted next after the current transaction.
//  beat_cnt width: $clog2(WRITE_BEATS)+1, no wrap. Outputs are combinational decodes of registered state.
// STRUCTURE
//  Shared package sysbus_pkg
//   TAG_W, TAG_RW_BIT, READ=1'b1, WRITE=1'b0, MEMORY kind code, LINE_BYTES=64, WRITE_BEATS.
//   typedef enum arb_state_t {IDLE,ISSUE,WDATA,WAIT,RESP}.
//  Sub-module rr_pick2
//   Inputs: req[1:0], last_grant. Outputs: gnt_valid, gnt_id. Purely combinational.
//  Everything else is flat in sysbus_arbiter.
// TESTING
//  1. m0 READ addr 0x1000 alone, bus acks at cycle 3, 8 resp beats.
//     -> bus_reqcyc from t+1 to ack, m0_reqack at ack, 8 m0_respcyc, m1_respcyc never set, then IDLE.
//  2. m0 and m1 request READ in the same cycle after reset.
//     -> m0 granted first; m1 issued on the bus after m0's burst ends; a third tie grants m0 again.
//  3. m1 WRITE addr 0x2040 with data 0..7.
//     -> bus sees addr then 8 data beats, each acked to m1 only; returns to IDLE after the 8th ack with no WAIT.
//  4. bus_reqack withheld 20 cycles.
//     -> bus_reqcyc/req/reqtag held stable; neither mN_reqack asserts.
//  5. bus_respcyc pulsed in IDLE.
//     -> bus_respack=1, unexp_resp=1 for 1 cycle, no mN_respcyc.
//  6. reset during beat 4 of a read response.
//     -> next cycle all outputs 0, state IDLE; a fresh m1 request is granted normally.

Source files
------------

// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions: tag layout, line geometry and arbiter states.
package sysbus_pkg;

   // Tag layout {rw, kind[3:0], id[7:0]}
   localparam int         TAG_W       = 13;
   localparam int         TAG_RW_BIT  = TAG_W - 1;
   localparam logic       READ        = 1'b1;
   localparam logic       WRITE       = 1'b0;
   localparam logic [3:0] MEMORY      = 4'b0001;

   // A write carries one 64-byte line as 64-bit data beats
   localparam int         LINE_BYTES  = 64;
   localparam int         WRITE_BEATS = LINE_BYTES / 8;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WDATA,
      WAIT,
      RESP
   } arb_state_t;

endpackage

// File: rtl/sysbus_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not granted last.
module rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic       gnt_valid_o,
   output logic       gnt_id_o
);

   // Choose the winner from the request pair and the previous owner
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      gnt_valid_o = |req_i;
      gnt_id_o    = 1'b0;
      if (req_i == 2'b11) begin
         gnt_id_o = ~last_grant_i;
      end else if (req_i[1]) begin
         gnt_id_o = 1'b1;
      end
   end

endmodule

// File: rtl/sysbus_arbiter.sv
// Shares the Sysbus master port between fetch (m0) and data (m1), one whole
// transaction at a time, with one transaction outstanding on the bus.
module sysbus_arbiter #(
   parameter int WRITE_BEATS = sysbus_pkg::WRITE_BEATS,
   parameter int TAG_W       = sysbus_pkg::TAG_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             m0_reqcyc,
   input  logic [63:0]      m0_req,
   input  logic [TAG_W-1:0] m0_reqtag,
   output logic             m0_reqack,
   output logic             m0_respcyc,
   output logic [63:0]      m0_resp,
   output logic [TAG_W-1:0] m0_resptag,
   input  logic             m0_respack,
   input  logic             m1_reqcyc,
   input  logic [63:0]      m1_req,
   input  logic [TAG_W-1:0] m1_reqtag,
   output logic             m1_reqack,
   output logic             m1_respcyc,
   output logic [63:0]      m1_resp,
   output logic [TAG_W-1:0] m1_resptag,
   input  logic             m1_respack,
   output logic             bus_reqcyc,
   output logic [63:0]      bus_req,
   output logic [TAG_W-1:0] bus_reqtag,
   input  logic             bus_reqack,
   input  logic             bus_respcyc,
   input  logic [63:0]      bus_resp,
   input  logic [TAG_W-1:0] bus_resptag,
   output logic             bus_respack,
   output logic             unexp_resp
);

   import sysbus_pkg::*;

   // One spare bit so the counter reaches WRITE_BEATS without wrapping
   localparam int CNT_W = $clog2(WRITE_BEATS) + 1;

   arb_state_t       state_q, state_d;
   logic             grant_q, grant_d;
   logic             last_grant_q, last_grant_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [63:0]      req_q, req_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             rst_q;

   logic             pick_valid;
   logic             pick_id;
   logic             g_reqcyc;
   logic [63:0]      g_req;
   logic             g_respack;
   logic             blocked;
   logic             ack_g;
   logic             resp_g;

   rr_pick2 u_pick (
      .req_i        ({m1_reqcyc, m0_reqcyc}),
      .last_grant_i (last_grant_q),
      .gnt_valid_o  (pick_valid),
      .gnt_id_o     (pick_id)
   );

   // Live signals of the current owner
   assign g_reqcyc  = grant_q ? m1_reqcyc  : m0_reqcyc;
   assign g_req     = grant_q ? m1_req     : m0_req;
   assign g_respack = grant_q ? m1_respack : m0_respack;

   // Outputs are forced quiet during reset and the cycle after it
   assign blocked = reset | rst_q;

   // Next-state: grant, issue, write beats, then read burst
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      req_d        = req_q;
      tag_d        = tag_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d = pick_id;
               req_d   = pick_id ? m1_req    : m0_req;
               tag_d   = pick_id ? m1_reqtag : m0_reqtag;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (bus_reqack) begin
               beat_cnt_d = '0;
               state_d    = (tag_q[TAG_W-1] == READ) ? WAIT : WDATA;
            end
         end
         WDATA: begin
            if (bus_reqack && g_reqcyc) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               if (beat_cnt_q == CNT_W'(WRITE_BEATS - 1)) begin
                  state_d      = IDLE;
                  last_grant_d = grant_q;
               end
            end
         end
         WAIT: begin
            if (bus_respcyc) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (!bus_respcyc) begin
               state_d      = IDLE;
               last_grant_d = grant_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode: drive the bus, route acks and response beats to the owner
   always_comb begin
      bus_reqcyc  = 1'b0;
      bus_req     = '0;
      bus_reqtag  = '0;
      bus_respack = 1'b0;
      unexp_resp  = 1'b0;
      ack_g       = 1'b0;
      resp_g      = 1'b0;
      m0_resp     = '0;
      m1_resp     = '0;
      m0_resptag  = '0;
      m1_resptag  = '0;
      if (!blocked) begin
         m0_resp    = bus_resp;
         m1_resp    = bus_resp;
         m0_resptag = bus_resptag;
         m1_resptag = bus_resptag;
         case (state_q)
            WAIT, RESP: begin
               resp_g      = bus_respcyc;
               bus_respack = g_respack;
            end
            default: begin
               // No read outstanding: swallow any stray beat and flag it
               bus_respack = bus_respcyc;
               unexp_resp  = bus_respcyc;
               if (state_q == ISSUE) begin
                  bus_reqcyc = 1'b1;
                  bus_req    = req_q;
                  bus_reqtag = tag_q;
                  ack_g      = bus_reqack;
               end else if (state_q == WDATA) begin
                  bus_reqcyc = g_reqcyc;
                  bus_req    = g_req;
                  bus_reqtag = tag_q;
                  ack_g      = bus_reqack & g_reqcyc;
               end
            end
         endcase
      end
      m0_reqack  = ack_g  & ~grant_q;
      m1_reqack  = ack_g  &  grant_q;
      m0_respcyc = resp_g & ~grant_q;
      m1_respcyc = resp_g &  grant_q;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         beat_cnt_q   <= '0;
         req_q        <= '0;
         tag_q        <= '0;
         rst_q        <= 1'b1;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         req_q        <= req_d;
         tag_q        <= tag_d;
         rst_q        <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Randomized bench for sysbus_arbiter: requesters and Sysbus are driven from
// transaction-level tasks; the expected owner comes from a round-robin model.
module tb_sysbus_arbiter;

   localparam int NB = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  mcyc;
   logic [63:0] mreq [2];
   logic [12:0] mtag [2];
   logic [1:0]  mrespack;
   logic        bus_reqack;
   logic        bus_respcyc;
   logic [63:0] bus_resp;
   logic [12:0] bus_resptag;

   logic        m0_reqack, m1_reqack, m0_respcyc, m1_respcyc;
   logic [63:0] m0_resp, m1_resp, bus_req;
   logic [12:0] m0_resptag, m1_resptag, bus_reqtag;
   logic        bus_reqcyc, bus_respack, unexp_resp;

   int vectors     = 0;
   int miscompares = 0;
   int last_win;   // model: owner of the last completed transaction

   always #5 clk = ~clk;

   sysbus_arbiter #(.WRITE_BEATS(NB), .TAG_W(13)) dut (
      .clk         (clk),
      .reset       (reset),
      .m0_reqcyc   (mcyc[0]),
      .m0_req      (mreq[0]),
      .m0_reqtag   (mtag[0]),
      .m0_reqack   (m0_reqack),
      .m0_respcyc  (m0_respcyc),
      .m0_resp     (m0_resp),
      .m0_resptag  (m0_resptag),
      .m0_respack  (mrespack[0]),
      .m1_reqcyc   (mcyc[1]),
      .m1_req      (mreq[1]),
      .m1_reqtag   (mtag[1]),
      .m1_reqack   (m1_reqack),
      .m1_respcyc  (m1_respcyc),
      .m1_resp     (m1_resp),
      .m1_resptag  (m1_resptag),
      .m1_respack  (mrespack[1]),
      .bus_reqcyc  (bus_reqcyc),
      .bus_req     (bus_req),
      .bus_reqtag  (bus_reqtag),
      .bus_reqack  (bus_reqack),
      .bus_respcyc (bus_respcyc),
      .bus_resp    (bus_resp),
      .bus_resptag (bus_resptag),
      .bus_respack (bus_respack),
      .unexp_resp  (unexp_resp)
   );

   // Observed control/request outputs packed as one word
   function automatic logic [83:0] snap();
      return {bus_reqcyc, bus_reqtag, bus_req, m1_reqack, m0_reqack,
              m1_respcyc, m0_respcyc, bus_respack, unexp_resp};
   endfunction

   function automatic logic [83:0] mk(input logic rc, input logic [12:0] t, input logic [63:0] a,
                                      input logic [1:0] rack, input logic [1:0] rcyc,
                                      input logic rsak, input logic ux);
      return {rc, t, a, rack, rcyc, rsak, ux};
   endfunction

   function automatic logic [1:0] oh(input int w);
      return (w == 1) ? 2'b10 : 2'b01;
   endfunction

   // Inputs change at posedge+2, outputs sampled at posedge+3
   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic new_req(input int r, input logic rw, input logic [63:0] addr);
      mreq[r] = addr;
      mtag[r] = {rw, 4'b0001, 8'($urandom)};
      mcyc[r] = 1'b1;
   endtask

   // Serve one transaction starting in an IDLE cycle. Owner is chosen by the
   // round-robin rule: lone requester wins, a tie goes to the one not served last.
   task automatic serve(input int ack_dly, input int nbeats, input int abort_beat, input bit seq_data);
      int          w;
      logic [12:0] t;
      logic [63:0] a;
      logic [83:0] exp;
      logic        ack;
      int          b;
      int          gap;
      w = (mcyc == 2'b11) ? (1 - last_win) : (mcyc[1] ? 1 : 0);
      t = mtag[w];
      a = mreq[w];
      // IDLE: request sampled, bus still quiet
      #1;
      vectors++;
      exp = mk(1'b0, '0, '0, 2'b00, 2'b00, 1'b0, 1'b0);
      if (snap() !== exp) begin
         miscompares++;
         $display("FAIL idle: got %h want %h", snap(), exp);
      end
      next_cycle();
      // ISSUE: latched request held until the bus acks
      for (int d = 0; d <= ack_dly; d++) begin
         ack        = (d == ack_dly);
         bus_reqack = ack;
         #1;
         vectors++;
         exp = mk(1'b1, t, a, ack ? oh(w) : 2'b00, 2'b00, 1'b0, 1'b0);
         if (snap() !== exp) begin
            miscompares++;
            $display("FAIL issue d=%0d owner=m%0d: got %h want %h", d, w, snap(), exp);
         end
         next_cycle();
      end
      bus_reqack = 1'b0;
      if (!t[12]) begin
         // Write: NB data beats passed through, ack only to the owner
         b = 0;
         mreq[w] = seq_data ? 64'(b) : {$urandom, $urandom};
         while (b < NB) begin
            ack        = ($urandom_range(3) != 0);
            bus_reqack = ack;
            #1;
            vectors++;
            exp = mk(1'b1, t, mreq[w], ack ? oh(w) : 2'b00, 2'b00, 1'b0, 1'b0);
            if (snap() !== exp) begin
               miscompares++;
               $display("FAIL wdata beat=%0d owner=m%0d: got %h want %h", b, w, snap(), exp);
            end
            next_cycle();
            if (ack) begin
               b++;
               mreq[w] = seq_data ? 64'(b) : {$urandom, $urandom};
            end
         end
         bus_reqack = 1'b0;
         mcyc[w]    = 1'b0;
         last_win   = w;
         return;
      end
      // Read: requester drops its request, bus idles, then a burst returns
      mcyc[w] = 1'b0;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
         #1;
         vectors++;
         exp = mk(1'b0, '0, '0, 2'b00, 2'b00, 1'b0, 1'b0);
         if (snap() !== exp) begin
            miscompares++;
            $display("FAIL wait g=%0d: got %h want %h", g, snap(), exp);
         end
         next_cycle();
      end
      b = 0;
      bus_resp = {$urandom, $urandom};
      while (b < nbeats) begin
         bus_respcyc = 1'b1;
         bus_resptag = t;
         mrespack    = 2'($urandom);
         if ($urandom_range(3) != 0) mrespack[w] = 1'b1;
         if (b == abort_beat) begin
            // Reset lands mid-burst: outputs quiet now and in the next cycle
            reset = 1'b1;
            #1;
            vectors++;
            if ({snap(), m0_resp, m1_resp} !== '0) begin
               miscompares++;
               $display("FAIL reset_mid: got %h want 0", {snap(), m0_resp, m1_resp});
            end
            next_cycle();
            reset = 1'b0;
            #1;
            vectors++;
            if ({snap(), m0_resp, m1_resp} !== '0) begin
               miscompares++;
               $display("FAIL after_reset_mid: got %h want 0", {snap(), m0_resp, m1_resp});
            end
            next_cycle();
            bus_respcyc = 1'b0;
            mrespack    = 2'b00;
            last_win    = 1;
            return;
         end
         #1;
         vectors++;
         exp = mk(1'b0, '0, '0, 2'b00, oh(w), mrespack[w], 1'b0);
         if (snap() !== exp) begin
            miscompares++;
            $display("FAIL resp beat=%0d owner=m%0d: got %h want %h", b, w, snap(), exp);
         end
         vectors++;
         if ({m0_resp, m1_resp, m0_resptag, m1_resptag} !== {bus_resp, bus_resp, bus_resptag, bus_resptag}) begin
            miscompares++;
            $display("FAIL resp_data beat=%0d: got %h %h want %h", b, m0_resp, m1_resp, bus_resp);
         end
         next_cycle();
         if (mrespack[w]) begin
            b++;
            bus_resp = {$urandom, $urandom};
         end
      end
      bus_respcyc = 1'b0;
      mrespack    = 2'b00;
      #1;
      vectors++;
      exp = mk(1'b0, '0, '0, 2'b00, 2'b00, 1'b0, 1'b0);
      if (snap() !== exp) begin
         miscompares++;
         $display("FAIL resp_end: got %h want %h", snap(), exp);
      end
      next_cycle();
      last_win = w;
   endtask

   // A response beat while nothing is outstanding is dropped and flagged once
   task automatic expect_unexp(input string tag);
      logic [83:0] exp;
      bus_respcyc = 1'b1;
      #1;
      vectors++;
      exp = mk(1'b0, '0, '0, 2'b00, 2'b00, 1'b1, 1'b1);
      if (snap() !== exp) begin
         miscompares++;
         $display("FAIL unexp %s: got %h want %h", tag, snap(), exp);
      end
      next_cycle();
      bus_respcyc = 1'b0;
      #1;
      vectors++;
      if (unexp_resp !== 1'b0 || bus_respack !== 1'b0) begin
         miscompares++;
         $display("FAIL unexp_clear %s: got %b%b want 00", tag, unexp_resp, bus_respack);
      end
      next_cycle();
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      bus_respcyc = 1'b1;
      bus_resp    = 64'hDEAD_BEEF_0123_4567;
      bus_resptag = 13'h1ABC;
      #1;
      vectors++;
      if ({snap(), m0_resp, m1_resp, m0_resptag, m1_resptag} !== '0) begin
         miscompares++;
         $display("FAIL reset_high: got %h want 0", snap());
      end
      next_cycle();
      reset = 1'b0;
      #1;
      vectors++;
      if ({snap(), m0_resp, m1_resp, m0_resptag, m1_resptag} !== '0) begin
         miscompares++;
         $display("FAIL reset_after: got %h want 0", snap());
      end
      next_cycle();
      bus_respcyc = 1'b0;
      last_win    = 1;
   endtask

   task automatic test_read_single();
      new_req(0, 1'b1, 64'h1000);
      serve(2, 8, -1, 1'b0);
   endtask

   task automatic test_tie();
      new_req(0, 1'b1, 64'h3000);
      new_req(1, 1'b1, 64'h4000);
      serve(0, 3, -1, 1'b0);   // m0 first
      serve(1, 2, -1, 1'b0);   // waiting m1 next
      new_req(0, 1'b1, 64'h3040);
      new_req(1, 1'b1, 64'h4040);
      serve(0, 1, -1, 1'b0);   // tie again goes back to m0
      serve(0, 1, -1, 1'b0);
   endtask

   task automatic test_write();
      new_req(1, 1'b0, 64'h2040);
      serve(0, 0, -1, 1'b1);
      expect_unexp("after_write");   // straight back to IDLE, no WAIT
   endtask

   task automatic test_ack_stall();
      new_req(1, 1'b1, 64'h5000);
      serve(20, 1, -1, 1'b0);
   endtask

   task automatic test_unexp();
      expect_unexp("idle");
   endtask

   task automatic test_reset_mid();
      new_req(0, 1'b1, 64'h6000);
      serve(1, 8, 4, 1'b0);
      expect_unexp("idle_after_reset");
      new_req(1, 1'b1, 64'h7000);
      serve(0, 2, -1, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         for (int r = 0; r < 2; r++) begin
            if (!mcyc[r] && $urandom_range(1) == 1)
               new_req(r, 1'($urandom_range(1)), {$urandom, $urandom});
         end
         if (mcyc == 2'b00)
            new_req(int'($urandom_range(1)), 1'($urandom_range(1)), {$urandom, $urandom});
         serve(int'($urandom_range(0, 4)), int'($urandom_range(1, 8)), -1, 1'b0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      mcyc        = 2'b00;
      mreq[0]     = '0;
      mreq[1]     = '0;
      mtag[0]     = '0;
      mtag[1]     = '0;
      mrespack    = 2'b00;
      bus_reqack  = 1'b0;
      bus_respcyc = 1'b0;
      bus_resp    = '0;
      bus_resptag = '0;
      last_win    = 1;
      next_cycle();
      test_reset();
      test_read_single();
      test_tie();
      test_write();
      test_ack_stall();
      test_unexp();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
